// File: rtl/vga_quadrant_renderer.sv
// 640x480@60 VGA renderer: white 2x2 grid dividers plus a green box in the player's quadrant.
// Latency: outputs for counter position (h,v) are registered one cycle after the counters hold (h,v).
// Backpressure: none; free-running raster, and X/Y are sampled once per frame on the last cycle.
module vga_quadrant_renderer #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int MARGIN    = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       X,
    input  logic       Y,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       video_on,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START   = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END     = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] H_HALF     = HW'(H_VISIBLE / 2);
    localparam logic [HW-1:0] H_DIV_LO   = HW'(H_VISIBLE / 2 - 1);
    localparam logic [HW-1:0] H_BOX_LO   = HW'(MARGIN);
    localparam logic [HW-1:0] H_BOX_HI   = HW'(H_VISIBLE / 2 - MARGIN);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START   = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END     = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] V_HALF     = VW'(V_VISIBLE / 2);
    localparam logic [VW-1:0] V_DIV_LO   = VW'(V_VISIBLE / 2 - 1);
    localparam logic [VW-1:0] V_BOX_LO   = VW'(MARGIN);
    localparam logic [VW-1:0] V_BOX_HI   = VW'(V_VISIBLE / 2 - MARGIN);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          pos_x;
    logic          pos_y;
    logic          end_of_line;
    logic          end_of_frame;

    // Decoded pixel attributes for the current counter position
    logic          visible;
    logic          hsync_nxt;
    logic          vsync_nxt;
    logic          qx;
    logic          qy;
    logic [HW-1:0] lx;
    logic [VW-1:0] ly;
    logic          on_divider;
    logic          in_box;
    logic [11:0]   rgb_nxt;

    assign end_of_line  = (hcount == H_LAST);
    assign end_of_frame = end_of_line && (vcount == V_LAST);

    // Raster counters: hcount every cycle, vcount on each line wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (end_of_line) begin
            hcount <= '0;
            if (vcount == V_LAST) begin
                vcount <= '0;
            end else begin
                vcount <= vcount + 1'b1;
            end
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    // Player position is taken only on the last cycle of a frame so a frame never tears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x <= 1'b0;
            pos_y <= 1'b0;
        end else if (end_of_frame) begin
            pos_x <= X;
            pos_y <= Y;
        end
    end

    // Pixel classification: sync windows, quadrant-local coordinates, colour priority
    always_comb begin
        visible    = (hcount < H_VIS_END) && (vcount < V_VIS_END);
        hsync_nxt  = !((hcount >= HS_START) && (hcount < HS_END));
        vsync_nxt  = !((vcount >= VS_START) && (vcount < VS_END));
        qx         = (hcount >= H_HALF);
        qy         = (vcount < V_HALF);
        lx         = qx ? (hcount - H_HALF) : hcount;
        ly         = qy ? vcount : (vcount - V_HALF);
        on_divider = (hcount == H_DIV_LO) || (hcount == H_HALF) ||
                     (vcount == V_DIV_LO) || (vcount == V_HALF);
        in_box     = (qx == pos_x) && (qy == pos_y) &&
                     (lx >= H_BOX_LO) && (lx < H_BOX_HI) &&
                     (ly >= V_BOX_LO) && (ly < V_BOX_HI);
        rgb_nxt    = 12'h000;
        if (visible) begin
            if (on_divider) begin
                rgb_nxt = 12'hFFF;
            end else if (in_box) begin
                rgb_nxt = 12'h0F0;
            end
        end
    end

    // Output registers keep sync, colour and markers aligned to the same pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            red         <= 4'h0;
            green       <= 4'h0;
            blue        <= 4'h0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            red         <= rgb_nxt[11:8];
            green       <= rgb_nxt[7:4];
            blue        <= rgb_nxt[3:0];
            video_on    <= visible;
            frame_start <= (hcount == '0) && (vcount == '0);
        end
    end

endmodule

// File: tb/tb_vga_quadrant_renderer.sv
module tb_vga_quadrant_renderer;

    // Reduced raster geometry so several whole frames fit in a short run
    localparam int HV = 64;
    localparam int HF = 2;
    localparam int HS = 6;
    localparam int HB = 2;
    localparam int VV = 48;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int MG = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       X = 1'b0;
    logic       Y = 1'b0;
    logic       hsync;
    logic       vsync;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       video_on;
    logic       frame_start;
    logic [15:0] dut_vec;

    int checks = 0;
    int fails  = 0;

    vga_quadrant_renderer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .MARGIN(MG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .X(X),
        .Y(Y),
        .hsync(hsync),
        .vsync(vsync),
        .red(red),
        .green(green),
        .blue(blue),
        .video_on(video_on),
        .frame_start(frame_start)
    );

    assign dut_vec = {hsync, vsync, red, green, blue, video_on, frame_start};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference picture: box is a rectangle inset from the chosen quadrant, dividers override it
    function automatic logic [15:0] ref_pixel(input int h, input int v, input bit px, input bit py);
        bit vis;
        bit hs_o;
        bit vs_o;
        bit fs;
        logic [11:0] rgb;
        int bx0;
        int by0;
        vis  = (h < HV) && (v < VV);
        hs_o = !((h >= HV + HF) && (h < HV + HF + HS));
        vs_o = !((v >= VV + VF) && (v < VV + VF + VS));
        fs   = (h == 0) && (v == 0);
        bx0  = px ? (HV / 2 + MG) : MG;
        by0  = py ? MG : (VV / 2 + MG);
        rgb  = 12'h000;
        if (vis) begin
            if (h == HV / 2 - 1 || h == HV / 2 || v == VV / 2 - 1 || v == VV / 2)
                rgb = 12'hFFF;
            else if (h >= bx0 && h < bx0 + HV / 2 - 2 * MG && v >= by0 && v < by0 + VV / 2 - 2 * MG)
                rgb = 12'h0F0;
        end
        return {hs_o, vs_o, rgb, vis, fs};
    endfunction

    // Model of which pixel the outputs show, counted in cycles since reset release
    int          cnt = 0;
    bit          m_valid = 1'b0;
    bit          mpos_x = 1'b0;
    bit          mpos_y = 1'b0;
    bit          disp_x = 1'b0;
    bit          disp_y = 1'b0;
    int          out_h = 0;
    int          out_v = 0;
    logic [15:0] exp_vec = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt = 0;
            m_valid = 1'b0;
            mpos_x = 1'b0;
            mpos_y = 1'b0;
        end else begin
            out_h   = cnt % HT;
            out_v   = cnt / HT;
            disp_x  = mpos_x;
            disp_y  = mpos_y;
            exp_vec = ref_pixel(out_h, out_v, disp_x, disp_y);
            m_valid = 1'b1;
            if (cnt == FRAME - 1) begin
                mpos_x = X;
                mpos_y = Y;
            end
            cnt = (cnt + 1) % FRAME;
        end
    end

    // Per-pixel comparison plus whole-frame statistics between frame_start pulses
    bit stat_ok = 1'b0;
    int since_fs = 0;
    int von_cnt = 0;
    int vs_cnt = 0;
    int hs_cnt = 0;
    int vs_first = -1;

    always @(negedge clk) begin
        if (reset) begin
            stat_ok = 1'b0;
        end else if (m_valid) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++;
                $display("FAIL pixel h=%0d v=%0d: got %h expected %h", out_h, out_v, dut_vec, exp_vec);
            end
            if (frame_start) begin
                if (stat_ok) begin
                    check("frame_period", since_fs, FRAME);
                    check("video_on_per_frame", von_cnt, HV * VV);
                    check("vsync_low_cycles", vs_cnt, VS * HT);
                    check("hsync_low_cycles", hs_cnt, HS * VT);
                    check("vsync_start", vs_first, (VV + VF) * HT);
                end
                stat_ok  = 1'b1;
                since_fs = 0;
                von_cnt  = 0;
                vs_cnt   = 0;
                hs_cnt   = 0;
                vs_first = -1;
            end
            if (video_on) von_cnt++;
            if (!hsync) hs_cnt++;
            if (!vsync) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = since_fs;
            end
            since_fs++;
        end
    end

    // Wait (bounded) until the outputs show pixel (h,v) drawn with player position (x,y)
    task automatic wait_pix(input bit anypos, input bit x, input bit y,
                            input int h, input int v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_valid && out_h == h && out_v == v && (anypos || (disp_x == x && disp_y == y))) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL wait_pixel h=%0d v=%0d pos=%0d%0d: not reached in %0d cycles", h, v, x, y, budget);
        end
    endtask

    typedef struct {
        bit          x;
        bit          y;
        int          h;
        int          v;
        logic [11:0] rgb;
        bit          von;
    } vec_t;

    vec_t vecs[18];
    bit   ok;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 31,  5, 12'hFFF, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 10, 10, 12'h000, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 33, 10, 12'h000, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 40, 10, 12'h0F0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 70, 10, 12'h000, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 40, 30, 12'h000, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 40, 10, 12'h000, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 10, 23, 12'hFFF, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 10, 30, 12'h0F0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 10, 50, 12'h000, 1'b0};
        vecs[10] = '{1'b0, 1'b1,  4,  4, 12'h0F0, 1'b1};
        vecs[11] = '{1'b0, 1'b1,  3, 10, 12'h000, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 28, 10, 12'h000, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 27, 19, 12'h0F0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 35, 28, 12'h000, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 36, 28, 12'h0F0, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 50, 40, 12'h0F0, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 63, 47, 12'h000, 1'b1};

        // Reset state, then the first edge after release shows pixel (0,0)
        repeat (3) @(negedge clk);
        check("reset_state", dut_vec, 16'hC000);
        reset = 1'b0;
        @(negedge clk);
        check("first_frame_start", {frame_start, video_on}, 2'b11);

        // Free run with random position changes; monitor checks every pixel and frame totals
        for (int f = 0; f < 2; f++) begin
            wait_pix(1'b1, 1'b0, 1'b0, $urandom_range(HT - 1), $urandom_range(VT - 1), 2 * FRAME, ok);
            X = 1'($urandom_range(1));
            Y = 1'($urandom_range(1));
            wait_pix(1'b1, 1'b0, 1'b0, 0, 0, 2 * FRAME, ok);
        end

        // Table of spot pixels under each player position
        for (int i = 0; i < 18; i++) begin
            X = vecs[i].x;
            Y = vecs[i].y;
            wait_pix(1'b0, vecs[i].x, vecs[i].y, vecs[i].h, vecs[i].v, 3 * FRAME, ok);
            if (ok) begin
                check($sformatf("vec%0d_rgb", i), {red, green, blue}, vecs[i].rgb);
                check($sformatf("vec%0d_video_on", i), video_on, vecs[i].von);
            end
        end

        // Mid-frame position change only shows up on the next frame
        X = 1'b1;
        Y = 1'b1;
        wait_pix(1'b0, 1'b1, 1'b1, 0, 10, 3 * FRAME, ok);
        X = 1'b0;
        Y = 1'b0;
        wait_pix(1'b0, 1'b1, 1'b1, 40, 15, FRAME, ok);
        if (ok) check("midframe_box_kept", {red, green, blue}, 12'h0F0);
        wait_pix(1'b0, 1'b0, 1'b0, 40, 10, 2 * FRAME, ok);
        if (ok) check("next_frame_old_quadrant", {red, green, blue}, 12'h000);
        wait_pix(1'b0, 1'b0, 1'b0, 10, 30, FRAME, ok);
        if (ok) check("next_frame_new_box", {red, green, blue}, 12'h0F0);

        // Change on the latch cycle itself is captured for the very next frame
        wait_pix(1'b1, 1'b0, 1'b0, HT - 2, VT - 1, 2 * FRAME, ok);
        X = 1'b1;
        Y = 1'b0;
        wait_pix(1'b0, 1'b1, 1'b0, 50, 40, FRAME, ok);
        if (ok) check("latch_cycle_capture", {red, green, blue}, 12'h0F0);

        // Asynchronous reset in mid-frame, then restart from (0,0)
        wait_pix(1'b1, 1'b0, 1'b0, 30, 10, 2 * FRAME, ok);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", dut_vec, 16'hC000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("restart_frame_start", {frame_start, video_on}, 2'b11);
        check("restart_pos_lower_left", {disp_x, disp_y}, 2'b00);
        wait_pix(1'b1, 1'b0, 1'b0, 1, 0, 2 * FRAME, ok);
        wait_pix(1'b1, 1'b0, 1'b0, 0, 0, 2 * FRAME, ok);
        wait_pix(1'b1, 1'b0, 1'b0, 2, 0, 2 * FRAME, ok);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
